plic_gateway: RTL and testbench

PLIC_GATEWAY -- requirements
Module: plic_gateway

---
 rtl/plic_pkg.sv | 10 +
 rtl/plic_gateway.sv | 79 +++++++
 tb/tb_plic_gateway.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_pkg.sv
// Shared PLIC types: per-source gateway state, visible to target and register blocks.
package plic_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StClaimed = 2'd2
  } plic_state_e;

endpackage

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway for one source: level/edge qualification, pending-edge
// counter, and the IDLE/PENDING/CLAIMED handshake with the target.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned MAX_PENDING_COUNT = 8,
  parameter int unsigned CNT_BITS          = $clog2(MAX_PENDING_COUNT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic edge_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o,
  output logic busy_o
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(MAX_PENDING_COUNT);
  localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

  plic_state_e         state_q, state_d;
  logic                src_q;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ip_q, busy_q;
  logic                rise, inc, dec;

  // Next state: only the transition legal for the current state can fire.
  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (edge_i ? (cnt_q != '0) : src_i) begin
          state_d = StPending;
          dec     = edge_i;
        end
      end
      StPending: if (claim_i)    state_d = StClaimed;
      StClaimed: if (complete_i) state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  // Edge counter: saturating, but a dequeue in the same cycle frees a slot.
  always_comb begin
    rise  = src_i & ~src_q;
    inc   = edge_i & rise & ((cnt_q != CntMax) | dec);
    cnt_d = cnt_q;
    if (!edge_i) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // State, counter, edge history and registered state-decoded outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      ip_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_i;
      cnt_q   <= cnt_d;
      ip_q    <= (state_d == StPending);
      busy_q  <= (state_d == StClaimed);
    end
  end

  assign ip_o   = ip_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: per-cycle expectation tables for level
// mode and a round-token scoreboard for edge mode.
module tb_plic_gateway;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic src_i = 1'b0;
  logic edge_i = 1'b0;
  logic claim_i = 1'b0;
  logic complete_i = 1'b0;
  logic ip_o;
  logic busy_o;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  logic ip_prev = 1'b0;

  logic [1:0] exp_q[$];  // {ip, busy} expected after each driven cycle
  int         tok_q[$];  // one token per expected service round

  plic_gateway #(
    .MAX_PENDING_COUNT(8),
    .CNT_BITS         (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .src_i     (src_i),
    .edge_i    (edge_i),
    .claim_i   (claim_i),
    .complete_i(complete_i),
    .ip_o      (ip_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (ip_o && !ip_prev) rises++;
    ip_prev = ip_o;
  endtask

  task automatic pulse();
    src_i = 1'b1;
    tick();
    src_i = 1'b0;
    tick();
  endtask

  task automatic do_reset(input logic mode);
    rst_ni = 1'b0;
    src_i = 1'b0; claim_i = 1'b0; complete_i = 1'b0;
    edge_i = mode;
    tick();
    tick();
    rst_ni = 1'b1;
    ip_prev = 1'b0;
    rises = 0;
    exp_q.delete();
    tok_q.delete();
  endtask

  // Services every request until the source stays quiet; pops one token per round.
  task automatic serve(input int budget, output int rounds, output int extra);
    int quiet = 0;
    rounds = 0;
    extra = 0;
    for (int i = 0; i < budget && quiet < 6; i++) begin
      if (ip_o) begin
        if (tok_q.size() == 0) extra++;
        else void'(tok_q.pop_front());
        claim_i = 1'b1; tick(); claim_i = 1'b0;
        complete_i = 1'b1; tick(); complete_i = 1'b0;
        rounds++;
        quiet = 0;
      end else begin
        tick();
        quiet++;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; src_i = 1'b1; claim_i = 1'b1; edge_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({ip_o, busy_o} !== 2'b00) begin
      failures++; $display("FAIL reset_out got=%b exp=00", {ip_o, busy_o});
    end
    checks++;
    if (dut.cnt_q !== 4'd0 || dut.src_q !== 1'b0) begin
      failures++; $display("FAIL reset_state got cnt=%0d src_q=%b exp cnt=0 src_q=0",
                           dut.cnt_q, dut.src_q);
    end
    src_i = 1'b0; claim_i = 1'b0;
  endtask

  task automatic test_level();
    logic [11:0] s  = 12'b101111110000;
    logic [11:0] c  = 12'b000100001000;
    logic [11:0] p  = 12'b000000100010;
    logic [11:0] ip = 12'b111000010000;
    logic [11:0] bz = 12'b000111001100;
    logic [1:0]  e;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      src_i = s[11-i]; claim_i = c[11-i]; complete_i = p[11-i];
      exp_q.push_back({ip[11-i], bz[11-i]});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({ip_o, busy_o} !== e) begin
        failures++; $display("FAIL level cyc%0d got ip/busy=%b exp=%b", i + 1, {ip_o, busy_o}, e);
      end
    end
    claim_i = 1'b0; complete_i = 1'b0;
    checks++;
    if (dut.cnt_q !== 4'd0) begin
      failures++; $display("FAIL level_cnt_held got=%0d exp=0", dut.cnt_q);
    end
  endtask

  task automatic test_spurious();
    logic [7:0] s  = 8'b00100000;
    logic [7:0] c  = 8'b01001110;
    logic [7:0] p  = 8'b10011010;
    logic [7:0] ip = 8'b00110000;
    logic [7:0] bz = 8'b00001100;
    logic [1:0] e;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      src_i = s[7-i]; claim_i = c[7-i]; complete_i = p[7-i];
      exp_q.push_back({ip[7-i], bz[7-i]});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({ip_o, busy_o} !== e) begin
        failures++; $display("FAIL spurious cyc%0d got ip/busy=%b exp=%b", i + 1, {ip_o, busy_o}, e);
      end
    end
    claim_i = 1'b0; complete_i = 1'b0;
  endtask

  task automatic test_edge_rounds();
    int rounds, extra;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      tok_q.push_back(i);
      pulse();
    end
    checks++;
    if (rises !== 1 || ip_o !== 1'b1) begin
      failures++; $display("FAIL edge_queued got rises=%0d ip=%b exp rises=1 ip=1", rises, ip_o);
    end
    checks++;
    if (dut.cnt_q !== 4'd2) begin
      failures++; $display("FAIL edge_cnt got=%0d exp=2", dut.cnt_q);
    end
    serve(200, rounds, extra);
    checks++;
    if (rounds !== 3 || extra !== 0 || tok_q.size() !== 0) begin
      failures++; $display("FAIL edge_rounds got rounds=%0d extra=%0d left=%0d exp 3/0/0",
                           rounds, extra, tok_q.size());
    end
    checks++;
    if (rises !== 3 || dut.cnt_q !== 4'd0) begin
      failures++; $display("FAIL edge_end got rises=%0d cnt=%0d exp rises=3 cnt=0",
                           rises, dut.cnt_q);
    end
  endtask

  task automatic test_saturation();
    int rounds, extra;
    int pend = 0;
    do_reset(1'b1);
    tok_q.push_back(0);
    pulse();
    checks++;
    if (ip_o !== 1'b1) begin
      failures++; $display("FAIL sat_first_ip got=%b exp=1", ip_o);
    end
    void'(tok_q.pop_front());
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pend < 8) begin
        pend++;
        tok_q.push_back(i + 1);
      end
      pulse();
    end
    checks++;
    if (busy_o !== 1'b1 || dut.cnt_q !== 4'(pend)) begin
      failures++; $display("FAIL sat_cnt got busy=%b cnt=%0d exp busy=1 cnt=%0d",
                           busy_o, dut.cnt_q, pend);
    end
    complete_i = 1'b1; tick(); complete_i = 1'b0;
    serve(400, rounds, extra);
    checks++;
    if (rounds + 1 !== 9 || extra !== 0 || tok_q.size() !== 0) begin
      failures++; $display("FAIL sat_rounds got total=%0d extra=%0d left=%0d exp 9/0/0",
                           rounds + 1, extra, tok_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int rounds, extra;
    int ip_seen = 0;
    do_reset(1'b1);
    pulse();
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    for (int i = 0; i < 5; i++) pulse();
    checks++;
    if (busy_o !== 1'b1 || dut.cnt_q !== 4'd5) begin
      failures++; $display("FAIL rmid_setup got busy=%b cnt=%0d exp busy=1 cnt=5",
                           busy_o, dut.cnt_q);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({ip_o, busy_o} !== 2'b00 || dut.cnt_q !== 4'd0) begin
      failures++; $display("FAIL rmid_async got ip/busy=%b cnt=%0d exp 00 cnt=0",
                           {ip_o, busy_o}, dut.cnt_q);
    end
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ip_o || busy_o) ip_seen++;
    end
    checks++;
    if (ip_seen !== 0) begin
      failures++; $display("FAIL rmid_quiet got active_cycles=%0d exp=0", ip_seen);
    end
    // Source already high across reset release counts as one edge.
    rst_ni = 1'b0; src_i = 1'b1;
    tick();
    rst_ni = 1'b1;
    tok_q.delete();
    tok_q.push_back(0);
    tick();
    tick();
    checks++;
    if (ip_o !== 1'b1) begin
      failures++; $display("FAIL rmid_high_src got ip=%b exp=1", ip_o);
    end
    src_i = 1'b0;
    serve(100, rounds, extra);
    checks++;
    if (rounds !== 1 || extra !== 0) begin
      failures++; $display("FAIL rmid_one_edge got rounds=%0d extra=%0d exp 1/0", rounds, extra);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b1);
    pulse();
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    pulse();
    complete_i = 1'b1; tick(); complete_i = 1'b0;
    checks++;
    if ({ip_o, busy_o} !== 2'b00 || dut.cnt_q !== 4'd1) begin
      failures++; $display("FAIL simul_setup got ip/busy=%b cnt=%0d exp 00 cnt=1",
                           {ip_o, busy_o}, dut.cnt_q);
    end
    src_i = 1'b1;
    tick();
    src_i = 1'b0;
    checks++;
    if (ip_o !== 1'b1 || dut.cnt_q !== 4'd1) begin
      failures++; $display("FAIL simul_edge_dequeue got ip=%b cnt=%0d exp ip=1 cnt=1",
                           ip_o, dut.cnt_q);
    end
  endtask

  task automatic test_mode_change();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) pulse();
    edge_i = 1'b0;
    tick();
    checks++;
    if (ip_o !== 1'b1 || dut.cnt_q !== 4'd0) begin
      failures++; $display("FAIL mode_switch got ip=%b cnt=%0d exp ip=1 cnt=0", ip_o, dut.cnt_q);
    end
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    complete_i = 1'b1; tick(); complete_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({ip_o, busy_o} !== 2'b00) begin
      failures++; $display("FAIL mode_drained got ip/busy=%b exp=00", {ip_o, busy_o});
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_spurious();
    test_edge_rounds();
    test_saturation();
    test_reset_mid();
    test_simultaneous();
    test_mode_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
